// File: rtl/timer_display_scan.sv
// rtl/timer_display_scan.sv - six-digit seven-segment scanner with state decoration and sand bar
// Optional macro LEADING_ZERO_BLANK_EN blanks leading hour zeros in IDLE_SET/RUNNING.
module timer_display_scan #(
    parameter int SCAN_DIV   = 1,
    parameter int BLINK_HALF = 500,
    parameter int RING_HALF  = 125
) (
    input  logic       clk_1k,
    input  logic       rst_n,
    input  logic [3:0] tm_h_tens,
    input  logic [3:0] tm_h_ones,
    input  logic [3:0] tm_m_tens,
    input  logic [3:0] tm_m_ones,
    input  logic [3:0] tm_s_tens,
    input  logic [3:0] tm_s_ones,
    input  logic [1:0] timer_state,
    input  logic [3:0] sand_count,
    output logic [7:0] seg_out,
    output logic [5:0] digit_sel,
    output logic [8:0] sand_led
);

    typedef enum logic [1:0] {
        ST_IDLE_SET = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_RINGING  = 2'd2,
        ST_CONFIRM  = 2'd3
    } timer_state_t;

    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = $clog2(2 * BLINK_HALF);
    localparam int RING_W  = $clog2(2 * RING_HALF);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
    localparam logic [RING_W-1:0]  RING_LAST  = RING_W'(2 * RING_HALF - 1);

    logic [2:0]         scan_idx;
    logic [DIV_W-1:0]   div_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [RING_W-1:0]  ring_cnt;
    timer_state_t       prev_state;
    timer_state_t       cur_state;
    logic               state_chg;
    logic               blink_on;
    logic               ring_on;
    logic               dp_slot;
    logic [3:0]         digit_val;
    logic [6:0]         digit_seg;
    logic [7:0]         seg_next;
    logic [5:0]         sel_next;
    logic [8:0]         sand_next;
`ifdef LEADING_ZERO_BLANK_EN
    logic               hour_blank;
`endif

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'h00;
        endcase
    endfunction

    always_comb begin
        cur_state = timer_state_t'(timer_state);
        state_chg = (cur_state != prev_state);
        blink_on  = (blink_cnt < BLINK_W'(BLINK_HALF));
        ring_on   = (ring_cnt < RING_W'(RING_HALF));
        case (scan_idx)
            3'd0:    digit_val = tm_h_tens;
            3'd1:    digit_val = tm_h_ones;
            3'd2:    digit_val = tm_m_tens;
            3'd3:    digit_val = tm_m_ones;
            3'd4:    digit_val = tm_s_tens;
            default: digit_val = tm_s_ones;
        endcase
        digit_seg = bcd_to_seg(digit_val);
        dp_slot   = (scan_idx == 3'd1) || (scan_idx == 3'd3);
        seg_next  = 8'h00;
        case (cur_state)
            ST_IDLE_SET: seg_next = {dp_slot, digit_seg};
            ST_RUNNING:  seg_next = {dp_slot & blink_on, digit_seg};
            ST_RINGING:  seg_next = ring_on ? {1'b0, digit_seg} : 8'h00;
            default: begin
                // "SEt" centred on digits 1..3
                case (scan_idx)
                    3'd1:    seg_next = 8'h6D;
                    3'd2:    seg_next = 8'h79;
                    3'd3:    seg_next = 8'h78;
                    default: seg_next = 8'h00;
                endcase
            end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        hour_blank = ((scan_idx == 3'd0) && (tm_h_tens == 4'd0)) ||
                     ((scan_idx == 3'd1) && (tm_h_tens == 4'd0) && (tm_h_ones == 4'd0));
        if (hour_blank && ((cur_state == ST_IDLE_SET) || (cur_state == ST_RUNNING)))
            seg_next = 8'h00;
`endif
        sel_next = 6'b000001 << scan_idx;
        for (int i = 0; i < 9; i++)
            sand_next[i] = (sand_count > 4'(i));
    end

    always_ff @(posedge clk_1k) begin
        if (!rst_n) begin
            seg_out    <= 8'h00;
            digit_sel  <= 6'b000000;
            sand_led   <= 9'h000;
            scan_idx   <= 3'd0;
            div_cnt    <= '0;
            blink_cnt  <= '0;
            ring_cnt   <= '0;
            prev_state <= ST_IDLE_SET;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                seg_out   <= seg_next;
                digit_sel <= sel_next;
                scan_idx  <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // restart both phases on entry so every state opens in its "on" phase
            if (state_chg) begin
                blink_cnt <= '0;
                ring_cnt  <= '0;
            end else begin
                blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
                ring_cnt  <= (ring_cnt == RING_LAST) ? '0 : ring_cnt + 1'b1;
            end
            prev_state <= cur_state;
            sand_led   <= sand_next;
        end
    end

endmodule
